run_ctrl: RTL and testbench
===========================

# run_ctrl

Synthesizable run controller for the single-cycle CPU, replacing the simulation-only run/halt/dump sequence with hardware.
- Holds the CPU in reset until started, then releases it and counts execution cycles.
- Stops on `halt` or an optional cycle-limit watchdog.
- Streams the full register file, then data memory, out over a valid/ready dump port.
- Sits between the CPU top level (`halt`, RF/DMEM debug read ports) and a host or trace sink.

## Interface
Parameters:
- `DATA_W`, 32, width of register/memory words
- `RF_DEPTH`, 32, registers dumped (indices 0..RF_DEPTH-1)
- `MEM_DEPTH`, 1024, memory words dumped (word addresses 0..MEM_DEPTH-1)
- `CYCLE_W`, 32, cycle counter width
- `TIMEOUT`, 0, watchdog limit in RUN cycles; 0 disables

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: single-cycle request to begin a run
- `halt` in 1: CPU halt flag
- `cpu_rst` out 1: active-low reset to CPU
- `rf_raddr` out clog2(RF_DEPTH): RF debug read address
- `rf_rdata` in DATA_W: RF debug read data, combinational from `rf_raddr`
- `mem_raddr` out clog2(MEM_DEPTH): DMEM debug read word address
- `mem_rdata` in DATA_W: DMEM debug read data, combinational
- `dump_valid` out 1: dump word available
- `dump_ready` in 1: sink accepts word
- `dump_sel` out 1: 0 = register word, 1 = memory word
- `dump_addr` out max(clog2(RF_DEPTH), clog2(MEM_DEPTH)): index of current word
- `dump_data` out DATA_W: current word
- `busy` out 1: state is PULSE, RUN, DUMP_RF or DUMP_MEM
- `done` out 1: state is DONE
- `timeout` out 1: sticky; run ended by watchdog
- `cycle_count` out CYCLE_W: RUN cycles executed

## Operation
- States: IDLE, PULSE, RUN, DUMP_RF, DUMP_MEM, DONE. Async reset enters IDLE.
- Reset values:
  - `cpu_rst`=0 and `cycle_count`=0.
  - `timeout`=0, `done`=0, `busy`=0, `dump_valid`=0.
  - Index counter, `dump_sel` and `dump_addr` all 0.
- IDLE:
  - `cpu_rst`=0.
  - `start`=1 → PULSE.
- PULSE:
  - Lasts exactly one cycle with `cpu_rst`=0.
  - Clears `cycle_count` and `timeout`.
  - → RUN.
- RUN:
  - `cpu_rst`=1.
  - Each cycle with `halt`=0: `cycle_count`+1, saturating at 2^CYCLE_W−1.
  - `halt`=1 → DUMP_RF with index 0; the count does not increment that cycle.
  - If TIMEOUT≠0, `halt`=0 and `cycle_count`==TIMEOUT−1: the count increments to TIMEOUT, `timeout` is set, → DUMP_RF.
  - Halt and watchdog in the same cycle: halt wins and `timeout` stays 0.
- DUMP_RF:
  - `cpu_rst`=1, so CPU state is preserved.
  - `rf_raddr`=index, `dump_sel`=0, `dump_addr`=index, `dump_data`=`rf_rdata`, `dump_valid`=1.
  - On `dump_valid`&`dump_ready`: index+1.
  - Handshake at index RF_DEPTH−1 → DUMP_MEM with index 0.
- DUMP_MEM:
  - Same as DUMP_RF but uses `mem_raddr`/`mem_rdata` and `dump_sel`=1.
  - Last handshake at index MEM_DEPTH−1 → DONE.
- DONE:
  - `done`=1 and `cpu_rst`=1.
  - `cycle_count` and `timeout` are held.
  - `start` → PULSE to re-run; memory is not reloaded.
- `start` is ignored in PULSE, RUN, DUMP_RF and DUMP_MEM.
- Address outputs not in use are driven 0.

## Timing
- Start to CPU release: `start` sampled high at edge N; PULSE during N→N+1; `cpu_rst`=1 from edge N+1.
- Halt to dump: `halt` high in RUN at edge M; first `dump_valid` cycle is M→M+1.
- Dump throughput: one word per cycle with `dump_ready` held high.
- Total dump: RF_DEPTH+MEM_DEPTH handshakes, all addresses in ascending order, no gaps or repeats.
- While `dump_valid`=1 and `dump_ready`=0: `dump_sel`, `dump_addr` and `dump_data` stay stable.
- `dump_valid` never drops without a handshake, except on `rst`.
- `dump_ready` is ignored outside the DUMP states.
- Index counter is sized so the RF_DEPTH−1 and MEM_DEPTH−1 comparisons never wrap early.
- `rst` asserted at any time returns all outputs to reset values immediately; an in-flight word is dropped.

## Test plan
Bench parameters: RF_DEPTH=4, MEM_DEPTH=8, DATA_W=32, TIMEOUT=0, with `dump_ready`=1 unless stated.

1. Basic run:
   - Stimulus: preload RF[i]=0x100+i and MEM[i]=0x200+i; pulse `start`; raise `halt` after 10 RUN cycles.
   - Required: `cpu_rst` low for exactly 1 cycle; `cycle_count`=10; 12 consecutive dump words: (0,0,0x100)…(0,3,0x103), then (1,0,0x200)…(1,7,0x207); then `done`=1 and `timeout`=0.
2. Backpressure:
   - Stimulus: toggle `dump_ready` on alternate cycles.
   - Required: same 12 words in order, each stable while stalled; dump takes 24 cycles.
3. Watchdog:
   - Stimulus: TIMEOUT=5; `halt` never asserted.
   - Required: `cycle_count`=5, `timeout`=1, and the full dump follows.
4. Simultaneous:
   - Stimulus: TIMEOUT=5; `halt`=1 in the cycle `cycle_count`=4.
   - Required: `timeout`=0 and `cycle_count`=4.
5. Reset mid-dump:
   - Stimulus: assert `rst` low during DUMP_MEM index 3.
   - Required: `dump_valid`=0, `cpu_rst`=0, `done`=0 and `cycle_count`=0 immediately; state is IDLE.
6. Restart and ignore:
   - Stimulus: `start` pulses during RUN and DUMP; then `start` in DONE.
   - Required: the pulses during RUN/DUMP have no effect; `start` in DONE produces a new PULSE with `cycle_count` and `timeout` cleared.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller for the single-cycle CPU: holds the CPU in reset until started,
// counts RUN cycles with an optional watchdog, then streams RF and DMEM out.
module run_ctrl #(
  parameter int DATA_W    = 32,
  parameter int RF_DEPTH  = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int CYCLE_W   = 32,
  parameter int TIMEOUT   = 0,
  localparam int RF_AW    = (RF_DEPTH  > 1) ? $clog2(RF_DEPTH)  : 1,
  localparam int MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int ADDR_W   = (RF_AW > MEM_AW) ? RF_AW : MEM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  output logic               cpu_rst,
  output logic [RF_AW-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic [MEM_AW-1:0]  mem_raddr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic               dump_sel,
  output logic [ADDR_W-1:0]  dump_addr,
  output logic [DATA_W-1:0]  dump_data,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PULSE    = 3'd1,
    S_RUN      = 3'd2,
    S_DUMP_RF  = 3'd3,
    S_DUMP_MEM = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0]  IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  RF_LAST  = ADDR_W'(RF_DEPTH - 1);
  localparam logic [ADDR_W-1:0]  MEM_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [CYCLE_W-1:0] CNT_ZERO = {CYCLE_W{1'b0}};
  localparam logic [CYCLE_W-1:0] CNT_ONE  = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] CNT_MAX  = {CYCLE_W{1'b1}};
  // The watchdog fires on the cycle that takes the count from TIMEOUT-1 to TIMEOUT.
  localparam logic [CYCLE_W-1:0] TO_LAST  = CYCLE_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic               WDOG_EN  = (TIMEOUT != 0);

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   idx_r;
  logic [CYCLE_W-1:0]  cycle_count_r;
  logic                timeout_r;
  logic                hs_s;
  logic                wdog_hit_s;

  assign hs_s       = dump_valid & dump_ready;
  // Halt has priority: the watchdog only counts as a hit on a non-halt cycle.
  assign wdog_hit_s = WDOG_EN & ~halt & (cycle_count_r == TO_LAST);

  assign cycle_count = cycle_count_r;
  assign timeout     = timeout_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_PULSE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PULSE: begin
        state_s = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_s = S_DUMP_RF;
        end else if (wdog_hit_s) begin
          state_s = S_DUMP_RF;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DUMP_RF: begin
        if (hs_s && (idx_r == RF_LAST)) begin
          state_s = S_DUMP_MEM;
        end else begin
          state_s = S_DUMP_RF;
        end
      end
      S_DUMP_MEM: begin
        if (hs_s && (idx_r == MEM_LAST)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DUMP_MEM;
        end
      end
      S_DONE: begin
        if (start) begin
          state_s = S_PULSE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state; unused read addresses are held at 0.
  always_comb begin
    cpu_rst    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    dump_valid = 1'b0;
    dump_sel   = 1'b0;
    dump_addr  = IDX_ZERO;
    dump_data  = {DATA_W{1'b0}};
    rf_raddr   = {RF_AW{1'b0}};
    mem_raddr  = {MEM_AW{1'b0}};
    case (state_r)
      S_IDLE: begin
        cpu_rst = 1'b0;
      end
      S_PULSE: begin
        busy = 1'b1;
      end
      S_RUN: begin
        cpu_rst = 1'b1;
        busy    = 1'b1;
      end
      S_DUMP_RF: begin
        cpu_rst    = 1'b1;
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_sel   = 1'b0;
        dump_addr  = idx_r;
        rf_raddr   = idx_r[RF_AW-1:0];
        dump_data  = rf_rdata;
      end
      S_DUMP_MEM: begin
        cpu_rst    = 1'b1;
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_sel   = 1'b1;
        dump_addr  = idx_r;
        mem_raddr  = idx_r[MEM_AW-1:0];
        dump_data  = mem_rdata;
      end
      S_DONE: begin
        cpu_rst = 1'b1;
        done    = 1'b1;
      end
      default: begin
        cpu_rst = 1'b0;
      end
    endcase
  end

  // Dump index: advances per handshake, rewinds at the end of each region.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= IDX_ZERO;
    end else begin
      case (state_r)
        S_DUMP_RF: begin
          if (hs_s) begin
            idx_r <= (idx_r == RF_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
          end else begin
            idx_r <= idx_r;
          end
        end
        S_DUMP_MEM: begin
          if (hs_s) begin
            idx_r <= (idx_r == MEM_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
          end else begin
            idx_r <= idx_r;
          end
        end
        default: begin
          idx_r <= IDX_ZERO;
        end
      endcase
    end
  end

  // Saturating RUN-cycle counter and sticky watchdog flag; both held after RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count_r <= CNT_ZERO;
      timeout_r     <= 1'b0;
    end else begin
      case (state_r)
        S_PULSE: begin
          cycle_count_r <= CNT_ZERO;
          timeout_r     <= 1'b0;
        end
        S_RUN: begin
          if (!halt) begin
            if (cycle_count_r != CNT_MAX) begin
              cycle_count_r <= cycle_count_r + CNT_ONE;
            end else begin
              cycle_count_r <= cycle_count_r;
            end
            if (wdog_hit_s) begin
              timeout_r <= 1'b1;
            end else begin
              timeout_r <= timeout_r;
            end
          end else begin
            cycle_count_r <= cycle_count_r;
            timeout_r     <= timeout_r;
          end
        end
        default: begin
          cycle_count_r <= cycle_count_r;
          timeout_r     <= timeout_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: one instance without and one with a
// 5-cycle watchdog, checked against a word-list model of the expected dump.
module tb_run_ctrl;

  localparam int DW  = 32;
  localparam int RFD = 4;
  localparam int MD  = 8;
  localparam int CW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, halt, dump_ready, use5;
  logic start0, start5;
  logic [DW-1:0] rf_arr [RFD];
  logic [DW-1:0] mem_arr [MD];

  logic          cpu_rst0, cpu_rst5, dv0, dv5, sel0, sel5, busy0, busy5, done0, done5, to0, to5;
  logic [1:0]    rf_raddr0, rf_raddr5;
  logic [2:0]    mem_raddr0, mem_raddr5, addr0, addr5;
  logic [DW-1:0] rf_rdata0, rf_rdata5, mem_rdata0, mem_rdata5, data0, data5;
  logic [CW-1:0] cnt0, cnt5;

  assign start0     = start & ~use5;
  assign start5     = start & use5;
  assign rf_rdata0  = rf_arr[rf_raddr0];
  assign mem_rdata0 = mem_arr[mem_raddr0];
  assign rf_rdata5  = rf_arr[rf_raddr5];
  assign mem_rdata5 = mem_arr[mem_raddr5];

  run_ctrl #(.DATA_W(DW), .RF_DEPTH(RFD), .MEM_DEPTH(MD), .CYCLE_W(CW), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .halt(halt), .cpu_rst(cpu_rst0),
    .rf_raddr(rf_raddr0), .rf_rdata(rf_rdata0), .mem_raddr(mem_raddr0), .mem_rdata(mem_rdata0),
    .dump_valid(dv0), .dump_ready(dump_ready), .dump_sel(sel0), .dump_addr(addr0), .dump_data(data0),
    .busy(busy0), .done(done0), .timeout(to0), .cycle_count(cnt0));

  run_ctrl #(.DATA_W(DW), .RF_DEPTH(RFD), .MEM_DEPTH(MD), .CYCLE_W(CW), .TIMEOUT(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .halt(halt), .cpu_rst(cpu_rst5),
    .rf_raddr(rf_raddr5), .rf_rdata(rf_rdata5), .mem_raddr(mem_raddr5), .mem_rdata(mem_rdata5),
    .dump_valid(dv5), .dump_ready(dump_ready), .dump_sel(sel5), .dump_addr(addr5), .dump_data(data5),
    .busy(busy5), .done(done5), .timeout(to5), .cycle_count(cnt5));

  logic          o_cpu_rst, o_valid, o_sel, o_busy, o_done, o_to;
  logic [1:0]    o_rf_raddr;
  logic [2:0]    o_mem_raddr, o_addr;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_cnt;

  assign o_cpu_rst   = use5 ? cpu_rst5   : cpu_rst0;
  assign o_valid     = use5 ? dv5        : dv0;
  assign o_sel       = use5 ? sel5       : sel0;
  assign o_busy      = use5 ? busy5      : busy0;
  assign o_done      = use5 ? done5      : done0;
  assign o_to        = use5 ? to5        : to0;
  assign o_rf_raddr  = use5 ? rf_raddr5  : rf_raddr0;
  assign o_mem_raddr = use5 ? mem_raddr5 : mem_raddr0;
  assign o_addr      = use5 ? addr5      : addr0;
  assign o_data      = use5 ? data5      : data0;
  assign o_cnt       = use5 ? cnt5       : cnt0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] got_q [$];
  int unstable;
  int addr_bad;

  // Expected k-th dump word {sel, addr, data}: all registers, then all memory words.
  function automatic logic [35:0] exp_word(input int k);
    if (k < RFD) return {1'b0, 3'(k), rf_arr[k]};
    else         return {1'b1, 3'(k - RFD), mem_arr[k - RFD]};
  endfunction

  function automatic logic [35:0] got_at(input int k);
    if (k >= 0 && k < got_q.size()) return got_q[k];
    else                            return 36'hx;
  endfunction

  function automatic int first_bad();
    for (int k = 0; k < RFD + MD; k++) begin
      if (k >= got_q.size()) return k;
      if (got_q[k] !== exp_word(k)) return k;
    end
    return -1;
  endfunction

  task automatic preload_fixed();
    for (int i = 0; i < RFD; i++) rf_arr[i] = 32'h100 + 32'(i);
    for (int i = 0; i < MD; i++)  mem_arr[i] = 32'h200 + 32'(i);
  endtask

  task automatic preload_random();
    for (int i = 0; i < RFD; i++) rf_arr[i] = $urandom();
    for (int i = 0; i < MD; i++)  mem_arr[i] = $urandom();
  endtask

  // Called at a negedge; returns at the first negedge with the CPU released.
  task automatic start_run(output int low, output bit ok);
    low = 0; ok = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_cpu_rst === 1'b1) begin ok = 1'b1; break; end
      low++;
      @(negedge clk);
    end
  endtask

  // Raises halt for one cycle once the count reads n; returns at the first dump cycle.
  task automatic run_phase(input int n, input bit start_mid, output int run_negs,
                           output int halt_lat, output bit ok);
    ok = 1'b0; run_negs = 0; halt_lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (o_valid === 1'b1) begin ok = 1'b1; break; end
      if (halt_lat >= 0) begin
        halt_lat++;
      end else begin
        run_negs++;
        if (o_cnt == 32'(n)) begin halt = 1'b1; halt_lat = 0; end
      end
      start = (start_mid && o_cnt == 32'd1);
      dump_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    halt = 1'b0; start = 1'b0;
  endtask

  // mode 0: ready high, 1: ready on every second dump cycle, 2: random ready.
  task automatic dump_phase(input int mode, input bit start_mid, output int cycles,
                            output int stalls, output bit ok);
    logic [35:0] prev;
    bit prev_stall;
    bit rdy;
    got_q.delete(); unstable = 0; addr_bad = 0; cycles = 0; stalls = 0; ok = 1'b0;
    prev_stall = 1'b0; prev = '0;
    for (int i = 0; i < 400; i++) begin
      if (o_done === 1'b1) begin ok = 1'b1; break; end
      if (o_valid !== 1'b1) begin
        unstable++;
        prev_stall = 1'b0;
      end else begin
        cycles++;
        if (prev_stall && ({o_sel, o_addr, o_data} !== prev)) unstable++;
        if (o_sel ? (o_mem_raddr !== o_addr || o_rf_raddr !== 2'd0)
                  : ({1'b0, o_rf_raddr} !== o_addr || o_mem_raddr !== 3'd0)) addr_bad++;
        if (mode == 0)      rdy = 1'b1;
        else if (mode == 1) rdy = (cycles % 2 == 0);
        else                rdy = ($urandom_range(0, 1) == 1);
        dump_ready = rdy;
        if (rdy) got_q.push_back({o_sel, o_addr, o_data});
        else     stalls++;
        prev_stall = !rdy;
        prev = {o_sel, o_addr, o_data};
      end
      start = (start_mid && cycles == 3);
      @(negedge clk);
    end
    dump_ready = 1'b1; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; halt = 1'b0; dump_ready = 1'b1; use5 = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      use5 = (s == 1);
      #1;
      n_cmp++; if (o_cpu_rst !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_rst[%0d]: got %b required 0", s, o_cpu_rst); end
      n_cmp++; if (o_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_count[%0d]: got %0d required 0", s, o_cnt); end
      n_cmp++; if ({o_to, o_done, o_busy, o_valid} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags[%0d]: got %b required 0000", s, {o_to, o_done, o_busy, o_valid}); end
      n_cmp++; if ({o_sel, o_addr} !== 4'b0000) begin n_bad++; $display("FAIL reset_dump_addr[%0d]: got %h required 0", s, {o_sel, o_addr}); end
    end
    use5 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({o_busy, o_cpu_rst} !== 2'b00) begin n_bad++; $display("FAIL reset_idle_hold: got %b required 00", {o_busy, o_cpu_rst}); end
  endtask

  task automatic test_basic_run();
    int low, rn, hl, cyc, st, fb;
    bit ok1, ok2, ok3;
    preload_fixed();
    use5 = 1'b0;
    start_run(low, ok1);
    run_phase(10, 1'b0, rn, hl, ok2);
    dump_phase(0, 1'b0, cyc, st, ok3);
    n_cmp++; if (low !== 1) begin n_bad++; $display("FAIL basic_pulse_len: got %0d required 1", low); end
    n_cmp++; if ({ok1, ok2, ok3} !== 3'b111) begin n_bad++; $display("FAIL basic_progress: got %b required 111", {ok1, ok2, ok3}); end
    n_cmp++; if (rn !== 11 || hl !== 0) begin n_bad++; $display("FAIL basic_run_timing: got run=%0d lat=%0d required run=11 lat=0", rn, hl); end
    n_cmp++; if (o_cnt !== 32'd10) begin n_bad++; $display("FAIL basic_count: got %0d required 10", o_cnt); end
    n_cmp++; if ({o_done, o_to, o_busy} !== 3'b100) begin n_bad++; $display("FAIL basic_done_flags: got %b required 100", {o_done, o_to, o_busy}); end
    n_cmp++; if (got_q.size() !== RFD + MD) begin n_bad++; $display("FAIL basic_word_count: got %0d required %0d", got_q.size(), RFD + MD); end
    fb = first_bad();
    n_cmp++; if (fb !== -1) begin n_bad++; $display("FAIL basic_words: word %0d got %h required %h", fb, got_at(fb), exp_word(fb)); end
    n_cmp++; if (cyc !== RFD + MD) begin n_bad++; $display("FAIL basic_dump_cycles: got %0d required %0d", cyc, RFD + MD); end
    n_cmp++; if (unstable !== 0 || addr_bad !== 0) begin n_bad++; $display("FAIL basic_dump_ports: got unstable=%0d addr_bad=%0d required 0/0", unstable, addr_bad); end
  endtask

  task automatic test_backpressure();
    int low, rn, hl, cyc, st, fb, n;
    bit ok1, ok2, ok3;
    preload_random();
    use5 = 1'b0;
    n = int'($urandom_range(1, 20));
    start_run(low, ok1);
    run_phase(n, 1'b0, rn, hl, ok2);
    dump_phase(1, 1'b0, cyc, st, ok3);
    n_cmp++; if ({ok1, ok2, ok3} !== 3'b111) begin n_bad++; $display("FAIL bp_progress: got %b required 111", {ok1, ok2, ok3}); end
    n_cmp++; if (o_cnt !== 32'(n)) begin n_bad++; $display("FAIL bp_count: got %0d required %0d", o_cnt, n); end
    fb = first_bad();
    n_cmp++; if (fb !== -1 || got_q.size() !== RFD + MD) begin n_bad++; $display("FAIL bp_words: word %0d got %h required %h (size %0d)", fb, got_at(fb), exp_word(fb), got_q.size()); end
    n_cmp++; if (cyc !== 2 * (RFD + MD)) begin n_bad++; $display("FAIL bp_dump_cycles: got %0d required %0d", cyc, 2 * (RFD + MD)); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable required 0", unstable); end
  endtask

  task automatic test_watchdog();
    int low, rn, hl, cyc, st, fb;
    bit ok1, ok2, ok3;
    preload_random();
    use5 = 1'b1;
    start_run(low, ok1);
    run_phase(1000, 1'b0, rn, hl, ok2);
    dump_phase(0, 1'b0, cyc, st, ok3);
    n_cmp++; if ({ok1, ok2, ok3} !== 3'b111) begin n_bad++; $display("FAIL wdog_progress: got %b required 111", {ok1, ok2, ok3}); end
    n_cmp++; if (rn !== 5) begin n_bad++; $display("FAIL wdog_run_cycles: got %0d required 5", rn); end
    n_cmp++; if (o_cnt !== 32'd5 || o_to !== 1'b1) begin n_bad++; $display("FAIL wdog_result: got count=%0d timeout=%b required 5/1", o_cnt, o_to); end
    fb = first_bad();
    n_cmp++; if (fb !== -1 || got_q.size() !== RFD + MD) begin n_bad++; $display("FAIL wdog_words: word %0d got %h required %h (size %0d)", fb, got_at(fb), exp_word(fb), got_q.size()); end
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL wdog_done: got %b required 1", o_done); end
  endtask

  task automatic test_simultaneous();
    int low, rn, hl, cyc, st, fb;
    bit ok1, ok2, ok3;
    preload_random();
    use5 = 1'b1;
    start_run(low, ok1);
    run_phase(4, 1'b0, rn, hl, ok2);
    dump_phase(0, 1'b0, cyc, st, ok3);
    n_cmp++; if ({ok1, ok2, ok3} !== 3'b111) begin n_bad++; $display("FAIL simul_progress: got %b required 111", {ok1, ok2, ok3}); end
    n_cmp++; if (o_cnt !== 32'd4 || o_to !== 1'b0) begin n_bad++; $display("FAIL simul_result: got count=%0d timeout=%b required 4/0", o_cnt, o_to); end
    n_cmp++; if (hl !== 0) begin n_bad++; $display("FAIL simul_halt_latency: got %0d required 0", hl); end
    fb = first_bad();
    n_cmp++; if (fb !== -1 || got_q.size() !== RFD + MD) begin n_bad++; $display("FAIL simul_words: word %0d got %h required %h (size %0d)", fb, got_at(fb), exp_word(fb), got_q.size()); end
  endtask

  task automatic test_reset_mid_dump();
    int low, rn, hl;
    bit ok1, ok2, found;
    preload_random();
    use5 = 1'b0;
    start_run(low, ok1);
    run_phase(2, 1'b0, rn, hl, ok2);
    found = 1'b0;
    dump_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (o_valid === 1'b1 && o_sel === 1'b1 && o_addr === 3'd3) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if ({ok1, ok2, found} !== 3'b111) begin n_bad++; $display("FAIL rstdump_reach: got %b required 111", {ok1, ok2, found}); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({o_valid, o_cpu_rst, o_done, o_busy} !== 4'b0000) begin n_bad++; $display("FAIL rstdump_flags: got %b required 0000", {o_valid, o_cpu_rst, o_done, o_busy}); end
    n_cmp++; if (o_cnt !== 32'd0) begin n_bad++; $display("FAIL rstdump_count: got %0d required 0", o_cnt); end
    n_cmp++; if ({o_sel, o_addr} !== 4'b0000) begin n_bad++; $display("FAIL rstdump_addr: got %h required 0", {o_sel, o_addr}); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({o_busy, o_cpu_rst, o_valid} !== 3'b000) begin n_bad++; $display("FAIL rstdump_idle: got %b required 000", {o_busy, o_cpu_rst, o_valid}); end
  endtask

  task automatic test_restart();
    int low, rn, hl, cyc, st, fb;
    bit ok1, ok2, ok3, ok4, ok5;
    preload_random();
    use5 = 1'b1;
    start_run(low, ok1);
    run_phase(1000, 1'b0, rn, hl, ok2);
    dump_phase(0, 1'b0, cyc, st, ok3);
    repeat (3) @(negedge clk);
    n_cmp++; if ({o_done, o_to} !== 2'b11 || o_cnt !== 32'd5) begin n_bad++; $display("FAIL restart_hold: got done/to=%b count=%0d required 11/5", {o_done, o_to}, o_cnt); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if ({o_cpu_rst, o_busy, o_done} !== 3'b010) begin n_bad++; $display("FAIL restart_pulse: got %b required 010", {o_cpu_rst, o_busy, o_done}); end
    @(negedge clk);
    n_cmp++; if (o_cnt !== 32'd0 || o_to !== 1'b0 || o_cpu_rst !== 1'b1) begin n_bad++; $display("FAIL restart_cleared: got count=%0d to=%b cpu_rst=%b required 0/0/1", o_cnt, o_to, o_cpu_rst); end
    run_phase(3, 1'b1, rn, hl, ok4);
    dump_phase(0, 1'b1, cyc, st, ok5);
    n_cmp++; if ({ok1, ok2, ok3, ok4, ok5} !== 5'b11111) begin n_bad++; $display("FAIL restart_progress: got %b required 11111", {ok1, ok2, ok3, ok4, ok5}); end
    n_cmp++; if (o_cnt !== 32'd3 || o_to !== 1'b0) begin n_bad++; $display("FAIL restart_ignore_count: got count=%0d to=%b required 3/0", o_cnt, o_to); end
    fb = first_bad();
    n_cmp++; if (fb !== -1 || got_q.size() !== RFD + MD) begin n_bad++; $display("FAIL restart_words: word %0d got %h required %h (size %0d)", fb, got_at(fb), exp_word(fb), got_q.size()); end
  endtask

  task automatic test_random();
    int low, rn, hl, cyc, st, fb, n, exp_cnt;
    bit ok1, ok2, ok3, exp_to;
    for (int it = 0; it < 6; it++) begin
      preload_random();
      use5 = ($urandom_range(0, 1) == 1);
      n = int'($urandom_range(0, 12));
      exp_to  = use5 && (n >= 5);
      exp_cnt = exp_to ? 5 : n;
      start_run(low, ok1);
      run_phase(n, 1'b0, rn, hl, ok2);
      dump_phase(2, 1'b0, cyc, st, ok3);
      n_cmp++; if ({ok1, ok2, ok3} !== 3'b111 || low !== 1) begin n_bad++; $display("FAIL rand%0d_progress: got %b low=%0d required 111 low=1", it, {ok1, ok2, ok3}, low); end
      n_cmp++; if (o_cnt !== 32'(exp_cnt) || o_to !== exp_to) begin n_bad++; $display("FAIL rand%0d_result: got count=%0d to=%b required %0d/%b", it, o_cnt, o_to, exp_cnt, exp_to); end
      fb = first_bad();
      n_cmp++; if (fb !== -1 || got_q.size() !== RFD + MD) begin n_bad++; $display("FAIL rand%0d_words: word %0d got %h required %h (size %0d)", it, fb, got_at(fb), exp_word(fb), got_q.size()); end
      n_cmp++; if (cyc !== RFD + MD + st) begin n_bad++; $display("FAIL rand%0d_dump_cycles: got %0d required %0d", it, cyc, RFD + MD + st); end
      n_cmp++; if (unstable !== 0 || addr_bad !== 0) begin n_bad++; $display("FAIL rand%0d_ports: got unstable=%0d addr_bad=%0d required 0/0", it, unstable, addr_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_backpressure();
    test_watchdog();
    test_simultaneous();
    test_reset_mid_dump();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
